// File: rtl/input_buffer_ctrl.sv
// Pointer, occupancy and handshake controller for the input-buffer circular
// queue. Drives the write/read ports of the dual-port vector RAM, keeps the
// per-entry eof flag in a flop side-array and delays pop/eof so that
// valid_out/eof_out line up with the RAM read data.
module input_buffer_ctrl #(
    parameter int IB_DEPTH    = 4,
    parameter int RAM_LATENCY = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enqueue,
    input  logic                           eof_in,
    input  logic                           dequeue,
    output logic                           wr_en,
    output logic [$clog2(IB_DEPTH)-1:0]    wr_addr,
    output logic                           rd_en,
    output logic [$clog2(IB_DEPTH)-1:0]    rd_addr,
    output logic                           valid_out,
    output logic                           eof_out,
    output logic [$clog2(IB_DEPTH+1)-1:0]  occupancy,
    output logic                           full,
    output logic                           empty,
    output logic                           overflow,
    output logic [CNT_WIDTH-1:0]           drop_count
);

    localparam int AW = $clog2(IB_DEPTH);
    localparam int OW = $clog2(IB_DEPTH+1);

    logic [AW-1:0]          head;
    logic [AW-1:0]          tail;
    logic [AW-1:0]          head_nxt;
    logic [AW-1:0]          tail_nxt;
    logic [OW-1:0]          occ_nxt;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic [IB_DEPTH-1:0]    eof_mem;
    logic [RAM_LATENCY-1:0] vld_pipe;
    logic [RAM_LATENCY-1:0] eof_pipe;

    // Handshake decode on pre-edge state; a full queue may still accept a
    // vector when the same cycle frees a slot. Pointers wrap by compare so
    // non-power-of-two depths work.
    always_comb begin
        pop      = dequeue && !empty;
        push     = enqueue && (!full || pop);
        drop     = enqueue && full && !pop;
        head_nxt = (head == AW'(IB_DEPTH-1)) ? '0 : head + AW'(1);
        tail_nxt = (tail == AW'(IB_DEPTH-1)) ? '0 : tail + AW'(1);
        occ_nxt  = occupancy;
        case ({push, pop})
            2'b10:   occ_nxt = occupancy + OW'(1);
            2'b01:   occ_nxt = occupancy - OW'(1);
            default: occ_nxt = occupancy;
        endcase
    end

    assign wr_en     = push;
    assign wr_addr   = head;
    assign rd_en     = pop;
    assign rd_addr   = tail;
    assign valid_out = vld_pipe[RAM_LATENCY-1];
    assign eof_out   = eof_pipe[RAM_LATENCY-1];

    // Queue pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            if (push)
                head <= head_nxt;
            if (pop)
                tail <= tail_nxt;
            occupancy <= occ_nxt;
            full      <= (occ_nxt == OW'(IB_DEPTH));
            empty     <= (occ_nxt == '0);
        end
    end

    // Per-entry eof side-array, written alongside the RAM write port.
    always_ff @(posedge clk) begin
        if (reset)
            eof_mem <= '0;
        else if (push)
            eof_mem[head] <= eof_in;
    end

    // Sticky overflow flag and saturating count of dropped enqueues.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1)
                drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

    // Delay line matching the RAM read latency; eof is qualified by pop so
    // eof_out never asserts without valid_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            eof_pipe <= '0;
        end else begin
            vld_pipe[0] <= pop;
            eof_pipe[0] <= pop && eof_mem[tail];
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                eof_pipe[i] <= eof_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Directed bench for input_buffer_ctrl: a depth-4/latency-1 instance with a
// 2-bit drop counter and a depth-3/latency-2 instance for eof alignment.
module tb_input_buffer_ctrl;

    logic clk;
    logic reset;

    logic       a_enq, a_eof, a_deq;
    logic       a_wr_en, a_rd_en, a_valid, a_eof_out, a_full, a_empty, a_ovf;
    logic [1:0] a_wr_addr, a_rd_addr;
    logic [2:0] a_occ;
    logic [1:0] a_drop;

    logic       b_enq, b_eof, b_deq;
    logic       b_wr_en, b_rd_en, b_valid, b_eof_out, b_full, b_empty, b_ovf;
    logic [1:0] b_wr_addr, b_rd_addr;
    logic [1:0] b_occ;
    logic [7:0] b_drop;

    int n_checks = 0;
    int n_pass   = 0;

    logic       exp_q[$];
    logic       exp_eof;
    logic [4:0] b_pat;

    input_buffer_ctrl #(.IB_DEPTH(4), .RAM_LATENCY(1), .CNT_WIDTH(2)) dut_a (
        .clk(clk), .reset(reset), .enqueue(a_enq), .eof_in(a_eof), .dequeue(a_deq),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .valid_out(a_valid), .eof_out(a_eof_out), .occupancy(a_occ), .full(a_full),
        .empty(a_empty), .overflow(a_ovf), .drop_count(a_drop)
    );

    input_buffer_ctrl #(.IB_DEPTH(3), .RAM_LATENCY(2), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .enqueue(b_enq), .eof_in(b_eof), .dequeue(b_deq),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .valid_out(b_valid), .eof_out(b_eof_out), .occupancy(b_occ), .full(b_full),
        .empty(b_empty), .overflow(b_ovf), .drop_count(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_enq = 0; a_eof = 0; a_deq = 0;
        b_enq = 0; b_eof = 0; b_deq = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        chk("rst_occ",   a_occ,     0);
        chk("rst_empty", a_empty,   1);
        chk("rst_full",  a_full,    0);
        chk("rst_ovf",   a_ovf,     0);
        chk("rst_drop",  a_drop,    0);
        chk("rst_valid", a_valid,   0);
        chk("rst_eof",   a_eof_out, 0);

        // depth 3, latency 2: eof alignment and non-power-of-two wrap
        b_pat = 5'b10100;
        for (int v = 0; v < 5; v++) begin
            b_enq = 1; b_eof = b_pat[v]; b_deq = 0;
            #1;
            chk("b_wr_en", b_wr_en, 1);
            chk("b_wr_addr", b_wr_addr, v % 3);
            tick();
            b_enq = 0; b_deq = 1;
            #1;
            chk("b_rd_en", b_rd_en, 1);
            chk("b_rd_addr", b_rd_addr, v % 3);
            tick();
            b_deq = 0;
            chk("b_valid_early", b_valid, 0);
            tick();
            chk("b_valid", b_valid, 1);
            chk("b_eof_out", b_eof_out, b_pat[v]);
        end
        tick();
        chk("b_valid_end", b_valid, 0);
        chk("b_empty_end", b_empty, 1);

        // fill
        for (int i = 0; i < 4; i++) begin
            a_enq = 1; a_deq = 0;
            #1;
            chk("fill_wr_en", a_wr_en, 1);
            chk("fill_wr_addr", a_wr_addr, i);
            tick();
        end
        chk("fill_full",  a_full,  1);
        chk("fill_occ",   a_occ,   4);
        chk("fill_empty", a_empty, 0);
        chk("fill_ovf",   a_ovf,   0);

        // drops while full, then saturation of the 2-bit counter
        for (int i = 0; i < 3; i++) begin
            a_enq = 1;
            #1;
            chk("drop_wr_en", a_wr_en, 0);
            tick();
        end
        chk("drop_ovf",  a_ovf,  1);
        chk("drop_cnt3", a_drop, 3);
        chk("drop_occ",  a_occ,  4);
        tick();
        tick();
        chk("drop_sat", a_drop, 3);

        // full with enqueue+dequeue: write into the freed slot, no drop
        a_enq = 1; a_deq = 1;
        #1;
        chk("fb_wr_en",   a_wr_en,   1);
        chk("fb_rd_en",   a_rd_en,   1);
        chk("fb_wr_addr", a_wr_addr, 0);
        chk("fb_rd_addr", a_rd_addr, 0);
        tick();
        chk("fb_occ",   a_occ,   4);
        chk("fb_full",  a_full,  1);
        chk("fb_valid", a_valid, 1);

        // drain
        a_enq = 0;
        for (int i = 0; i < 4; i++) begin
            a_deq = 1;
            #1;
            chk("drain_rd_en", a_rd_en, 1);
            chk("drain_rd_addr", a_rd_addr, (i + 1) % 4);
            tick();
            chk("drain_valid", a_valid, 1);
        end
        chk("drain_empty", a_empty, 1);
        chk("drain_occ",   a_occ,   0);

        // dequeue on empty is ignored
        #1;
        chk("emp_rd_en", a_rd_en, 0);
        tick();
        chk("emp_valid", a_valid, 0);

        // empty queue, enqueue+dequeue: no bypass
        a_enq = 1; a_deq = 1;
        #1;
        chk("eb_rd_en",   a_rd_en,   0);
        chk("eb_wr_en",   a_wr_en,   1);
        chk("eb_wr_addr", a_wr_addr, 1);
        tick();
        chk("eb_occ",   a_occ,   1);
        chk("eb_valid", a_valid, 0);
        a_enq = 0;
        #1;
        chk("eb_rd_en2",   a_rd_en,   1);
        chk("eb_rd_addr2", a_rd_addr, 1);
        tick();
        chk("eb_valid2", a_valid, 1);
        chk("eb_empty2", a_empty, 1);
        a_deq = 0;
        tick();
        chk("eb_valid3", a_valid, 0);

        // steady enqueue+dequeue at occupancy 2, ordering via eof tags
        exp_q.delete();
        a_enq = 1; a_eof = 1;
        #1;
        chk("ss_pre_addr0", a_wr_addr, 2);
        tick();
        exp_q.push_back(1'b1);
        a_eof = 0;
        #1;
        chk("ss_pre_addr1", a_wr_addr, 3);
        tick();
        exp_q.push_back(1'b0);
        chk("ss_pre_occ", a_occ, 2);
        for (int k = 0; k < 10; k++) begin
            a_enq = 1; a_deq = 1; a_eof = (k % 2 == 1);
            #1;
            chk("ss_wr_addr", a_wr_addr, k % 4);
            chk("ss_rd_addr", a_rd_addr, (2 + k) % 4);
            exp_eof = exp_q.pop_front();
            exp_q.push_back(a_eof);
            tick();
            chk("ss_occ",   a_occ,     2);
            chk("ss_valid", a_valid,   1);
            chk("ss_eof",   a_eof_out, exp_eof);
        end
        a_enq = 0;
        for (int k = 0; k < 2; k++) begin
            a_deq = 1;
            #1;
            exp_eof = exp_q.pop_front();
            tick();
            chk("ss_drain_valid", a_valid,   1);
            chk("ss_drain_eof",   a_eof_out, exp_eof);
        end
        a_deq = 0;
        chk("ss_empty", a_empty, 1);

        // reset with a pop in flight
        for (int i = 0; i < 3; i++) begin
            a_enq = 1;
            tick();
        end
        a_enq = 0; a_deq = 1;
        tick();
        chk("mr_occ_pre", a_occ, 2);
        reset = 1;
        tick();
        reset = 0; a_deq = 0;
        chk("mr_valid", a_valid, 0);
        chk("mr_occ",   a_occ,   0);
        chk("mr_empty", a_empty, 1);
        chk("mr_full",  a_full,  0);
        chk("mr_ovf",   a_ovf,   0);
        chk("mr_drop",  a_drop,  0);
        a_enq = 1;
        #1;
        chk("mr_wr_en",   a_wr_en,   1);
        chk("mr_wr_addr", a_wr_addr, 0);
        tick();
        a_enq = 0;
        chk("mr_occ_post", a_occ, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
